// File: rtl/conv_operand_feeder.sv
// Operand feeder for a convolver: buffers an image and a kernel, then streams them as A/B beats
// after holding the convolver in reset. Define FEEDER_ZERO_KERNEL_PAD_EN to zero B past the kernel.
module conv_operand_feeder #(
  parameter int unsigned Width      = 32,
  parameter int unsigned MAXN       = 8,
  parameter int unsigned MAXM       = 4,
  parameter int unsigned RST_CYCLES = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       N,
  input  logic [5:0]       M,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [5:0]       wr_addr,
  input  logic [Width-1:0] wr_data,
  input  logic             start,
  output logic [Width-1:0] A,
  output logic [Width-1:0] B,
  output logic             conv_rst,
  output logic             a_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned IMG_DEPTH = MAXN * MAXN;
  localparam int unsigned KER_DEPTH = MAXM * MAXM;
  localparam int unsigned IAW       = (IMG_DEPTH > 1) ? $clog2(IMG_DEPTH) : 1;
  localparam int unsigned KAW       = (KER_DEPTH > 1) ? $clog2(KER_DEPTH) : 1;
  localparam int unsigned CW        = $clog2(IMG_DEPTH + 1);
  localparam int unsigned RCW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CRST   = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;

  logic [Width-1:0] r_img [IMG_DEPTH];
  logic [Width-1:0] r_ker [KER_DEPTH];

  logic [2:0]     r_state;
  logic [RCW-1:0] r_rcnt;
  logic [CW-1:0]  r_beat;
  logic [5:0]     r_n;
  logic [5:0]     r_m;

  logic [2:0]     w_state_nxt;
  logic [RCW-1:0] w_rcnt_nxt;
  logic [CW-1:0]  w_beat_nxt;
  logic [5:0]     w_n_nxt;
  logic [5:0]     w_m_nxt;
  logic           w_valid_nxt;
  logic           w_done_nxt;
  logic           w_err_nxt;
  logic           w_busy_nxt;
  logic           w_crst_nxt;

  logic [CW-1:0]  w_nn;
  logic [CW-1:0]  w_mm;
  logic [CW-1:0]  w_kidx;
  logic [31:0]    w_waddr;
  logic [31:0]    w_n32;
  logic [31:0]    w_m32;
  logic           w_start_ok;
  logic           w_img_we;
  logic           w_ker_we;

  assign w_nn    = CW'(r_n) * CW'(r_n);
  assign w_mm    = CW'(r_m) * CW'(r_m);
  // Past the last kernel word, keep addressing it so the non-padded build can hold it.
  assign w_kidx  = (r_beat < w_mm) ? r_beat : (w_mm - CW'(1));

  assign w_n32      = 32'(N);
  assign w_m32      = 32'(M);
  assign w_start_ok = (M != 6'd0) && (M <= N) && (w_n32 <= MAXN) && (w_m32 <= MAXM);

  assign w_waddr  = 32'(wr_addr);
  assign w_img_we = wr_en && !busy && !wr_sel && (w_waddr < IMG_DEPTH);
  assign w_ker_we = wr_en && !busy &&  wr_sel && (w_waddr < KER_DEPTH);

  // Operand buffers; deliberately not reset so contents survive RST.
  always_ff @(posedge CLK) begin
    if (w_img_we) r_img[IAW'(wr_addr)] <= wr_data;
    if (w_ker_we) r_ker[KAW'(wr_addr)] <= wr_data;
  end

  // Next-state and next-output decode; r_beat is the prefetched index of the next beat.
  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_beat_nxt  = r_beat;
    w_n_nxt     = r_n;
    w_m_nxt     = r_m;
    w_valid_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_start_ok) begin
            w_state_nxt = S_CRST;
            w_rcnt_nxt  = '0;
            w_n_nxt     = N;
            w_m_nxt     = M;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_CRST: begin
        if (r_rcnt == RCW'(RST_CYCLES - 1)) begin
          w_state_nxt = S_GAP;
          w_beat_nxt  = '0;
        end else begin
          w_rcnt_nxt = r_rcnt + RCW'(1);
        end
      end
      S_GAP: begin
        w_state_nxt = S_STREAM;
        w_valid_nxt = 1'b1;
        w_beat_nxt  = r_beat + CW'(1);
      end
      S_STREAM: begin
        if (r_beat == w_nn) begin
          w_state_nxt = S_FIN;
          w_done_nxt  = 1'b1;
        end else begin
          w_valid_nxt = 1'b1;
          w_beat_nxt  = r_beat + CW'(1);
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_crst_nxt = (w_state_nxt == S_CRST);
  end

  // State and registered outputs; A/B come straight from the synchronous buffer reads.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_rcnt   <= '0;
      r_beat   <= '0;
      r_n      <= '0;
      r_m      <= '0;
      A        <= '0;
      B        <= '0;
      conv_rst <= 1'b0;
      a_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rcnt   <= w_rcnt_nxt;
      r_beat   <= w_beat_nxt;
      r_n      <= w_n_nxt;
      r_m      <= w_m_nxt;
      conv_rst <= w_crst_nxt;
      a_valid  <= w_valid_nxt;
      busy     <= w_busy_nxt;
      done     <= w_done_nxt;
      err      <= w_err_nxt;
      A        <= w_valid_nxt ? r_img[IAW'(r_beat)] : '0;
`ifdef FEEDER_ZERO_KERNEL_PAD_EN
      B        <= (w_valid_nxt && (r_beat < w_mm)) ? r_ker[KAW'(w_kidx)] : '0;
`else
      B        <= w_valid_nxt ? r_ker[KAW'(w_kidx)] : '0;
`endif
    end
  end

endmodule

// File: tb/tb_conv_operand_feeder.sv
// Scoreboard bench for conv_operand_feeder: a task issues feeds and queues expected beats,
// a negedge monitor pops and compares every valid beat.
module tb_conv_operand_feeder;

  localparam int RC = 12;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [5:0]  N = '0;
  logic [5:0]  M = '0;
  logic        wr_en = 1'b0;
  logic        wr_sel = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        start = 1'b0;
  logic [31:0] A;
  logic [31:0] B;
  logic        conv_rst;
  logic        a_valid;
  logic        busy;
  logic        done;
  logic        err;

  conv_operand_feeder dut (
    .CLK(CLK), .RST(RST), .N(N), .M(M),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .A(A), .B(B), .conv_rst(conv_rst),
    .a_valid(a_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int beats_seen = 0;

  logic [31:0] img_m [64];
  logic [31:0] ker_m [16];
  logic [31:0] exp_a [$];
  logic [31:0] exp_b [$];

  localparam logic [31:0] NOM_IMG [9] = '{32'h400CCCCD, 32'h3FC00000, 32'h40B00000,
                                         32'h400CCCCD, 32'h3FC00000, 32'h400CCCCD,
                                         32'h3FC00000, 32'h400CCCCD, 32'h400CCCCD};
  localparam logic [31:0] NOM_KER [4] = '{32'h400CCCCD, 32'h40B00000, 32'h400CCCCD, 32'h400CCCCD};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every valid beat must match the head of the expected queue.
  always @(negedge CLK) begin
    if (a_valid) begin
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=%h/%h required=none", A, B);
      end else begin
        chk("beat_A", A, exp_a.pop_front());
        chk("beat_B", B, exp_b.pop_front());
      end
      beats_seen++;
    end else begin
      chk("idle_A", A, 32'h0);
      chk("idle_B", B, 32'h0);
    end
  end

  // Reference: beat k carries image[k] and kernel[k], the kernel tail padded per build.
  task automatic push_expected(input int n, input int m);
    for (int k = 0; k < n * n; k++) begin
      exp_a.push_back(img_m[k]);
      if (k < m * m) exp_b.push_back(ker_m[k]);
`ifdef FEEDER_ZERO_KERNEL_PAD_EN
      else exp_b.push_back(32'h0);
`else
      else exp_b.push_back(ker_m[m * m - 1]);
`endif
    end
  endtask

  // Called right after a negedge; returns right after a negedge.
  task automatic write_word(input bit sel, input int addr, input logic [31:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 6'(addr); wr_data = data;
    @(negedge CLK);
    wr_en = 1'b0;
    if (!sel && addr < 64) img_m[addr] = data;
    if (sel && addr < 16) ker_m[addr] = data;
  endtask

  task automatic load_nominal();
    for (int i = 0; i < 9; i++) write_word(1'b0, i, NOM_IMG[i]);
    for (int i = 0; i < 4; i++) write_word(1'b1, i, NOM_KER[i]);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_A"}, A, 32'h0);
    chk({tag, "_B"}, B, 32'h0);
    chk({tag, "_conv_rst"}, 32'(conv_rst), 32'h0);
    chk({tag, "_a_valid"}, 32'(a_valid), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
  endtask

  task automatic run_feed(input int n, input int m, input int rst_beat,
                          input bit restart_mid, input bit busy_write);
    int nn;
    nn = n * n;
    N = 6'(n);
    M = 6'(m);
    push_expected(n, m);
    beats_seen = 0;
    start = 1'b1;
    for (int cyc = 1; cyc <= RC + 3 + nn; cyc++) begin
      @(negedge CLK);
      if (cyc == 1) start = 1'b0;
      if (rst_beat >= 0 && cyc == RC + 3 + rst_beat) begin
        check_all_zero("after_rst");
        chk("beats_before_rst", 32'(beats_seen), 32'(rst_beat + 1));
        RST = 1'b0;
        exp_a.delete();
        exp_b.delete();
        return;
      end
      chk("conv_rst", 32'(conv_rst), 32'(cyc <= RC));
      chk("a_valid", 32'(a_valid), 32'(cyc >= RC + 2 && cyc <= RC + 1 + nn));
      chk("done", 32'(done), 32'(cyc == RC + 2 + nn));
      chk("busy", 32'(busy), 32'(cyc <= RC + 2 + nn));
      chk("err", 32'(err), 32'h0);
      if (busy_write && cyc == 5) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd0; wr_data = 32'hFFFFFFFF;
      end
      if (busy_write && cyc == 6) wr_en = 1'b0;
      if (restart_mid && cyc == RC + 4) start = 1'b1;
      if (restart_mid && cyc == RC + 5) start = 1'b0;
      if (rst_beat >= 0 && cyc == RC + 2 + rst_beat) RST = 1'b1;
    end
    chk("beat_count", 32'(beats_seen), 32'(nn));
    chk("queue_empty", 32'(exp_a.size()), 32'h0);
  endtask

  task automatic reject(input int n, input int m);
    N = 6'(n);
    M = 6'(m);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("rej_err", 32'(err), 32'h1);
    chk("rej_busy", 32'(busy), 32'h0);
    chk("rej_conv_rst", 32'(conv_rst), 32'h0);
    @(negedge CLK);
    chk("rej_err_clear", 32'(err), 32'h0);
    chk("rej_busy2", 32'(busy), 32'h0);
    chk("rej_conv_rst2", 32'(conv_rst), 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;
    @(negedge CLK);
    @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;
    @(negedge CLK);

    load_nominal();
    run_feed(3, 2, -1, 1'b0, 1'b0);

    reject(2, 3);
    reject(9, 2);
    reject(4, 0);
    reject(6, 5);

    run_feed(3, 2, 4, 1'b0, 1'b0);
    @(negedge CLK);
    run_feed(3, 2, -1, 1'b0, 1'b0);

    run_feed(3, 2, -1, 1'b0, 1'b1);
    run_feed(3, 2, -1, 1'b1, 1'b0);

    // Out-of-range kernel addresses must not alias onto stored words.
    write_word(1'b1, 16, 32'hDEADBEEF);
    write_word(1'b1, 63, 32'hCAFEF00D);
    run_feed(3, 2, -1, 1'b0, 1'b0);

    for (int it = 0; it < 6; it++) begin
      if (it == 0) begin n = 1; m = 1; end
      else if (it == 1) begin n = 8; m = 4; end
      else begin
        n = int'($urandom_range(1, 8));
        m = int'($urandom_range(1, (n < 4) ? n : 4));
      end
      for (int i = 0; i < n * n; i++) write_word(1'b0, i, $urandom);
      for (int i = 0; i < m * m; i++) write_word(1'b1, i, $urandom);
      run_feed(n, m, -1, 1'b0, 1'b0);
    end

    @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
